// File: rtl/vote_session_ctrl.sv
`timescale 1ns/1ps
// vote_session_ctrl
// Session sequencer and four-booth round-robin arbiter for the vote counter.
// Walks IDLE -> OPEN -> CLOSED -> CLEARING -> IDLE on console commands. Allows
// one vote per arming, and presents at most one vote at a time to the counter
// datapath over valid/ready.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   open_cmd/close_cmd/clear_cmd  console command pulses (clear > close > open)
//   arm[3:0]                      per-booth arm pulses
//   booth_req[3:0], booth_cand[7:0]  booth requests, candidate per booth (2 bits)
//   booth_ack[3:0]                one-cycle pulse when a booth's vote is accepted
//   vote_valid, vote_cand, vote_ready  vote handshake to the counter datapath
//   counter_clear                 one-cycle clear pulse to the counter datapath
//   state[1:0]                    00 IDLE, 01 OPEN, 10 CLOSED, 11 CLEARING
//   booth_armed[3:0]              armed booths
//   booth_timeout[3:0]            one-cycle pulse when a booth is disarmed by timeout
//   votes_cast[7:0]               accepted votes this session, saturating at 255
module vote_session_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       open_cmd,
  input  logic       close_cmd,
  input  logic       clear_cmd,
  input  logic [3:0] arm,
  input  logic [3:0] booth_req,
  input  logic [7:0] booth_cand,
  output logic [3:0] booth_ack,
  output logic       vote_valid,
  output logic [1:0] vote_cand,
  input  logic       vote_ready,
  output logic       counter_clear,
  output logic [1:0] state,
  output logic [3:0] booth_armed,
  output logic [3:0] booth_timeout,
  output logic [7:0] votes_cast
);

  localparam int unsigned NB = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 2;
  localparam int unsigned TW = 8;
  localparam int unsigned VW = 8;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [VW-1:0] VOTES_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_OPEN     = 2'b01,
    ST_CLOSED   = 2'b10,
    ST_CLEARING = 2'b11
  } state_e;

  state_e         st_q, st_d;
  logic           close_pend_q, close_pend_d;
  logic [IW-1:0]  rr_q, rr_d;
  logic [IW-1:0]  gidx_q, gidx_d;
  logic           valid_q, valid_d;
  logic [CW-1:0]  cand_q, cand_d;
  logic [NB-1:0]  ack_q, ack_d;
  logic [NB-1:0]  armed_q, armed_d;
  logic [NB-1:0]  tmo_q, tmo_d;
  logic [VW-1:0]  votes_q, votes_d;
  logic           clr_q, clr_d;
  logic [TW-1:0]  timer_q [NB];
  logic [TW-1:0]  timer_d [NB];

  logic [NB-1:0]  eligible;
  logic           grant;
  logic [IW-1:0]  gsel;
  logic           hs;
  logic           go_closed;

  // Round-robin pick: first eligible booth after the pointer, pointer itself last.
  always_comb begin
    logic [IW-1:0] idx;
    eligible = booth_req & armed_q;
    gsel     = rr_q;
    grant    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= int'(NB); k++) begin
      idx = rr_q + IW'(k);
      if (!grant && eligible[idx]) begin
        gsel  = idx;
        grant = 1'b1;
      end
    end
    if (st_q != ST_OPEN || close_pend_q || valid_q) begin
      grant = 1'b0;
    end
  end

  assign hs        = valid_q & vote_ready;
  // A pending close waits for any outstanding vote to finish its handshake.
  assign go_closed = (st_q == ST_OPEN) && close_pend_q && (!valid_q || vote_ready);

  // Next-state and next-output logic.
  always_comb begin
    st_d         = st_q;
    close_pend_d = close_pend_q;
    rr_d         = rr_q;
    gidx_d       = gidx_q;
    valid_d      = valid_q;
    cand_d       = cand_q;
    ack_d        = '0;
    tmo_d        = '0;
    clr_d        = 1'b0;
    armed_d      = armed_q;
    votes_d      = votes_q;
    timer_d      = timer_q;

    // Session sequencing; illegal commands are simply ignored.
    case (st_q)
      ST_IDLE: begin
        if (clear_cmd) begin
          st_d = ST_CLEARING;
        end else if (open_cmd) begin
          st_d = ST_OPEN;
        end
      end
      ST_OPEN: begin
        if (go_closed) begin
          st_d         = ST_CLOSED;
          close_pend_d = 1'b0;
        end else if (close_cmd) begin
          close_pend_d = 1'b1;
        end
      end
      ST_CLOSED: begin
        if (clear_cmd) begin
          st_d = ST_CLEARING;
        end
      end
      ST_CLEARING: begin
        st_d = ST_IDLE;
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase

    // Arming only sets bits; an already-armed booth keeps its timer.
    if (st_q == ST_IDLE || st_q == ST_OPEN) begin
      armed_d = armed_q | arm;
    end

    // Idle timers for armed, ungranted booths; a coinciding grant beats the timeout.
    for (int i = 0; i < int'(NB); i++) begin
      if (st_q == ST_OPEN && armed_q[i] && !(valid_q && gidx_q == IW'(i))) begin
        if (grant && gsel == IW'(i)) begin
          timer_d[i] = '0;
        end else if (timer_q[i] == TMO_LAST) begin
          timer_d[i] = '0;
          tmo_d[i]   = 1'b1;
          armed_d[i] = 1'b0;
        end else begin
          timer_d[i] = timer_q[i] + TW'(1);
        end
      end
    end

    // Grant: latch candidate and booth so they stay stable while valid.
    if (grant) begin
      valid_d = 1'b1;
      cand_d  = booth_cand[{gsel, 1'b0} +: CW];
      gidx_d  = gsel;
      rr_d    = gsel;
    end

    // Handshake: acknowledge and disarm; this overrides a same-cycle arm.
    if (hs) begin
      valid_d         = 1'b0;
      ack_d[gidx_q]   = 1'b1;
      armed_d[gidx_q] = 1'b0;
      if (votes_q != VOTES_MAX) begin
        votes_d = votes_q + VW'(1);
      end
    end

    if (st_d == ST_CLEARING) begin
      clr_d   = 1'b1;
      votes_d = '0;
    end

    if (go_closed || st_q == ST_CLEARING) begin
      armed_d = '0;
    end
    if (st_q == ST_CLEARING) begin
      votes_d = '0;
    end

    // Disarmed booths always hold a zero timer.
    for (int i = 0; i < int'(NB); i++) begin
      if (!armed_d[i]) begin
        timer_d[i] = '0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= ST_IDLE;
      close_pend_q <= 1'b0;
      rr_q         <= IW'(NB - 1);
      gidx_q       <= '0;
      valid_q      <= 1'b0;
      cand_q       <= '0;
      ack_q        <= '0;
      armed_q      <= '0;
      tmo_q        <= '0;
      votes_q      <= '0;
      clr_q        <= 1'b0;
      for (int i = 0; i < int'(NB); i++) begin
        timer_q[i] <= '0;
      end
    end else begin
      st_q         <= st_d;
      close_pend_q <= close_pend_d;
      rr_q         <= rr_d;
      gidx_q       <= gidx_d;
      valid_q      <= valid_d;
      cand_q       <= cand_d;
      ack_q        <= ack_d;
      armed_q      <= armed_d;
      tmo_q        <= tmo_d;
      votes_q      <= votes_d;
      clr_q        <= clr_d;
      for (int i = 0; i < int'(NB); i++) begin
        timer_q[i] <= timer_d[i];
      end
    end
  end

  assign state         = st_q;
  assign vote_valid    = valid_q;
  assign vote_cand     = cand_q;
  assign booth_ack     = ack_q;
  assign booth_armed   = armed_q;
  assign booth_timeout = tmo_q;
  assign votes_cast    = votes_q;
  assign counter_clear = clr_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
`timescale 1ns/1ps
// tb_vote_session_ctrl
// Self-checking bench: directed vector table, hand-written corner sequences,
// and a randomized run compared cycle-by-cycle against a behavioural model.
// A second instance with a short timeout covers the disarm-by-timeout path.
module tb_vote_session_ctrl;

  localparam int unsigned TMO = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       open_cmd, close_cmd, clear_cmd, vote_ready;
  logic [3:0] arm, booth_req;
  logic [7:0] booth_cand;
  logic [3:0] booth_ack, booth_armed, booth_timeout;
  logic       vote_valid, counter_clear;
  logic [1:0] vote_cand, state;
  logic [7:0] votes_cast;

  logic       t_open, t_close, t_clear, t_ready;
  logic [3:0] t_arm, t_req;
  logic [7:0] t_cand;
  logic [3:0] t_ack, t_armed, t_tmo;
  logic       t_valid, t_clr;
  logic [1:0] t_vcand, t_state;
  logic [7:0] t_votes;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vote_session_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .open_cmd(open_cmd), .close_cmd(close_cmd),
    .clear_cmd(clear_cmd), .arm(arm), .booth_req(booth_req), .booth_cand(booth_cand),
    .booth_ack(booth_ack), .vote_valid(vote_valid), .vote_cand(vote_cand),
    .vote_ready(vote_ready), .counter_clear(counter_clear), .state(state),
    .booth_armed(booth_armed), .booth_timeout(booth_timeout), .votes_cast(votes_cast)
  );

  vote_session_ctrl #(.TIMEOUT_CYCLES(4)) dut_t4 (
    .clk(clk), .rst_n(rst_n), .open_cmd(t_open), .close_cmd(t_close),
    .clear_cmd(t_clear), .arm(t_arm), .booth_req(t_req), .booth_cand(t_cand),
    .booth_ack(t_ack), .vote_valid(t_valid), .vote_cand(t_vcand),
    .vote_ready(t_ready), .counter_clear(t_clr), .state(t_state),
    .booth_armed(t_armed), .booth_timeout(t_tmo), .votes_cast(t_votes)
  );

  wire [25:0] obs   = {state, vote_valid, vote_cand, booth_ack, booth_armed,
                       booth_timeout, votes_cast, counter_clear};
  wire [25:0] t_obs = {t_state, t_valid, t_vcand, t_ack, t_armed, t_tmo, t_votes, t_clr};

  // ---------------- behavioural reference model ----------------
  int       m_st, m_ptr, m_cand, m_g, m_votes;
  bit       m_pend, m_valid, m_clr;
  bit [3:0] m_armed, m_ack, m_tmo;
  int       m_timer [4];

  task automatic model_reset();
    m_st = 0; m_ptr = 3; m_cand = 0; m_g = 0; m_votes = 0;
    m_pend = 0; m_valid = 0; m_clr = 0;
    m_armed = 0; m_ack = 0; m_tmo = 0;
    for (int i = 0; i < 4; i++) m_timer[i] = 0;
  endtask

  task automatic model_step();
    int win;
    bit was_valid;
    bit [3:0] pre_armed;
    was_valid = m_valid;
    pre_armed = m_armed;
    win = -1;
    if (m_st == 1 && !m_pend && !m_valid) begin
      for (int k = 1; k <= 4; k++) begin
        int b;
        b = (m_ptr + k) % 4;
        if (win < 0 && booth_req[b] && pre_armed[b]) win = b;
      end
    end
    m_ack = 0; m_tmo = 0; m_clr = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_st == 1 && pre_armed[i] && !(was_valid && m_g == i)) begin
        if (win == i) m_timer[i] = 0;
        else if (m_timer[i] + 1 >= int'(TMO)) begin
          m_tmo[i] = 1; m_armed[i] = 0; m_timer[i] = 0;
        end else m_timer[i] = m_timer[i] + 1;
      end
    end
    if (m_st == 0 || m_st == 1) m_armed = m_armed | (arm & ~pre_armed);
    if (was_valid && vote_ready) begin
      m_ack[m_g] = 1; m_armed[m_g] = 0; m_valid = 0;
      if (m_votes < 255) m_votes = m_votes + 1;
    end
    if (win >= 0) begin
      m_valid = 1; m_cand = int'(booth_cand[2*win +: 2]); m_g = win; m_ptr = win;
    end
    case (m_st)
      0: if (clear_cmd) m_st = 3; else if (open_cmd) m_st = 1;
      1: if (m_pend && (!was_valid || vote_ready)) begin
           m_st = 2; m_pend = 0; m_armed = 0;
         end else if (close_cmd) m_pend = 1;
      2: if (clear_cmd) m_st = 3;
      default: begin m_st = 0; m_armed = 0; m_votes = 0; end
    endcase
    if (m_st == 3) begin m_clr = 1; m_votes = 0; end
    for (int i = 0; i < 4; i++) if (!m_armed[i]) m_timer[i] = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  function automatic logic [25:0] model_obs();
    return {2'(m_st), m_valid, 2'(m_cand), m_ack, m_armed, m_tmo, 8'(m_votes), m_clr};
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    open_cmd = 0; close_cmd = 0; clear_cmd = 0; arm = 0; booth_req = 0;
    booth_cand = 0; vote_ready = 0;
    t_open = 0; t_close = 0; t_clear = 0; t_arm = 0; t_req = 0; t_cand = 0; t_ready = 0;
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  typedef struct {
    logic       op, cl, cr;
    logic [3:0] arm, req;
    logic [7:0] cand;
    logic       rdy;
    logic [1:0] st;
    logic       vv;
    logic [1:0] vc;
    logic [3:0] ack, armed, tmo;
    logic [7:0] votes;
    logic       cc;
  } vec_t;

  function automatic vec_t mk(input logic op, input logic cl, input logic cr,
                              input logic [3:0] a, input logic [3:0] rq,
                              input logic [7:0] cd, input logic rd,
                              input logic [1:0] st, input logic vv, input logic [1:0] vc,
                              input logic [3:0] ak, input logic [3:0] am,
                              input logic [3:0] to, input logic [7:0] vt, input logic cc);
    vec_t v;
    v.op = op; v.cl = cl; v.cr = cr; v.arm = a; v.req = rq; v.cand = cd; v.rdy = rd;
    v.st = st; v.vv = vv; v.vc = vc; v.ack = ak; v.armed = am; v.tmo = to;
    v.votes = vt; v.cc = cc;
    return v;
  endfunction

  vec_t tbl [17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nack, b;
    int ec [4];

    // Inputs before an edge, outputs expected just after it.
    //             op cl cr arm     req     cand   rdy st    vv vc ack     armed   tmo  votes cc
    tbl[0]  = mk(1, 0, 0, 4'h0, 4'h0, 8'h00, 0, 2'b01, 0, 0, 4'h0, 4'h0, 4'h0, 8'd0, 0);
    tbl[1]  = mk(0, 0, 0, 4'h4, 4'h0, 8'h00, 0, 2'b01, 0, 0, 4'h0, 4'h4, 4'h0, 8'd0, 0);
    tbl[2]  = mk(0, 0, 0, 4'h0, 4'h4, 8'h30, 1, 2'b01, 1, 3, 4'h0, 4'h4, 4'h0, 8'd0, 0);
    tbl[3]  = mk(0, 0, 0, 4'h0, 4'h4, 8'h30, 1, 2'b01, 0, 3, 4'h4, 4'h0, 4'h0, 8'd1, 0);
    tbl[4]  = mk(0, 0, 0, 4'h0, 4'h0, 8'h00, 1, 2'b01, 0, 3, 4'h0, 4'h0, 4'h0, 8'd1, 0);
    tbl[5]  = mk(0, 1, 0, 4'h0, 4'h0, 8'h00, 0, 2'b01, 0, 3, 4'h0, 4'h0, 4'h0, 8'd1, 0);
    tbl[6]  = mk(0, 0, 0, 4'h0, 4'h0, 8'h00, 0, 2'b10, 0, 3, 4'h0, 4'h0, 4'h0, 8'd1, 0);
    tbl[7]  = mk(1, 0, 0, 4'h0, 4'h0, 8'h00, 0, 2'b10, 0, 3, 4'h0, 4'h0, 4'h0, 8'd1, 0);
    tbl[8]  = mk(0, 0, 0, 4'hF, 4'h0, 8'h00, 0, 2'b10, 0, 3, 4'h0, 4'h0, 4'h0, 8'd1, 0);
    tbl[9]  = mk(1, 0, 1, 4'h0, 4'h0, 8'h00, 0, 2'b11, 0, 3, 4'h0, 4'h0, 4'h0, 8'd0, 1);
    tbl[10] = mk(0, 0, 0, 4'h0, 4'h0, 8'h00, 0, 2'b00, 0, 3, 4'h0, 4'h0, 4'h0, 8'd0, 0);
    tbl[11] = mk(0, 0, 1, 4'h0, 4'h0, 8'h00, 0, 2'b11, 0, 3, 4'h0, 4'h0, 4'h0, 8'd0, 1);
    tbl[12] = mk(0, 0, 0, 4'h0, 4'h0, 8'h00, 0, 2'b00, 0, 3, 4'h0, 4'h0, 4'h0, 8'd0, 0);
    tbl[13] = mk(0, 0, 0, 4'h1, 4'h0, 8'h00, 0, 2'b00, 0, 3, 4'h0, 4'h1, 4'h0, 8'd0, 0);
    tbl[14] = mk(0, 1, 0, 4'h0, 4'h0, 8'h00, 0, 2'b00, 0, 3, 4'h0, 4'h1, 4'h0, 8'd0, 0);
    tbl[15] = mk(0, 0, 1, 4'h0, 4'h0, 8'h00, 0, 2'b11, 0, 3, 4'h0, 4'h1, 4'h0, 8'd0, 1);
    tbl[16] = mk(0, 0, 0, 4'h0, 4'h0, 8'h00, 0, 2'b00, 0, 3, 4'h0, 4'h0, 4'h0, 8'd0, 0);

    do_reset();
    chk("reset", 32'(obs), 32'h0);
    chk("reset_t4", 32'(t_obs), 32'h0);

    // ---- vector table ----
    for (int i = 0; i < 17; i++) begin
      open_cmd = tbl[i].op; close_cmd = tbl[i].cl; clear_cmd = tbl[i].cr;
      arm = tbl[i].arm; booth_req = tbl[i].req; booth_cand = tbl[i].cand;
      vote_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d", i), 32'(obs),
          32'({tbl[i].st, tbl[i].vv, tbl[i].vc, tbl[i].ack, tbl[i].armed,
               tbl[i].tmo, tbl[i].votes, tbl[i].cc}));
    end

    // ---- four booths, round-robin from booth 0 ----
    do_reset();
    open_cmd = 1; step(); open_cmd = 0;
    arm = 4'hF; step(); arm = 0;
    booth_req = 4'hF; booth_cand = 8'h39; vote_ready = 1;
    ec[0] = 1; ec[1] = 2; ec[2] = 3; ec[3] = 0;
    nack = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      step();
      if (booth_ack != 4'h0) begin
        b = -1;
        for (int j = 0; j < 4; j++) if (booth_ack[j]) b = (b < 0) ? j : 9;
        chk("rr_order", 32'(b), 32'(nack));
        chk("rr_spacing", 32'(cyc), 32'(2 * nack + 1));
        if (nack < 4) chk("rr_cand", 32'(vote_cand), 32'(ec[nack]));
        booth_req = booth_req & ~booth_ack;
        nack++;
      end
    end
    chk("rr_count", 32'(nack), 32'd4);
    chk("rr_votes", 32'(votes_cast), 32'd4);
    booth_req = 0; vote_ready = 0;

    // ---- stalled vote with close in the middle ----
    do_reset();
    open_cmd = 1; step(); open_cmd = 0;
    arm = 4'h1; step(); arm = 0;
    booth_req = 4'h1; booth_cand = 8'h02; vote_ready = 0;
    step();
    chk("stall_grant", 32'({state, vote_valid, vote_cand}), 32'({2'b01, 1'b1, 2'd2}));
    for (int s = 0; s < 5; s++) begin
      arm = (s == 0) ? 4'h2 : 4'h0;
      booth_req = (s == 0) ? 4'h0 : 4'h2;
      booth_cand = 8'h0D;
      close_cmd = (s == 1);
      step();
      chk($sformatf("stall%0d", s), 32'({state, vote_valid, vote_cand, booth_ack}),
          32'({2'b01, 1'b1, 2'd2, 4'h0}));
    end
    close_cmd = 0; vote_ready = 1;
    step();
    chk("stall_close", 32'({state, vote_valid, booth_ack, booth_armed, votes_cast}),
        32'({2'b10, 1'b0, 4'h1, 4'h0, 8'd1}));
    vote_ready = 0;
    step();
    chk("stall_after", 32'({state, vote_valid, booth_ack}), 32'({2'b10, 1'b0, 4'h0}));
    booth_req = 0;

    // ---- timeout on the short-timeout instance ----
    do_reset();
    t_open = 1; step(); t_open = 0;
    chk("t4_open", 32'(t_state), 32'h1);
    t_arm = 4'h2; step(); t_arm = 0;
    chk("t4_armed", 32'(t_armed), 32'h2);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("t4_wait%0d", k), 32'({t_armed, t_tmo}), 32'({4'h2, 4'h0}));
    end
    step();
    chk("t4_timeout", 32'({t_armed, t_tmo}), 32'({4'h0, 4'h2}));
    step();
    chk("t4_pulse_end", 32'(t_tmo), 32'h0);
    t_req = 4'h2; t_cand = 8'h0C; t_ready = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t4_nogrant%0d", k), 32'({t_valid, t_ack}), 32'h0);
    end
    t_req = 0; t_ready = 0;

    // ---- saturation at 255, then reset mid-handshake ----
    do_reset();
    open_cmd = 1; step(); open_cmd = 0;
    booth_req = 4'h1; booth_cand = 8'h01; vote_ready = 1;
    for (int v = 1; v <= 256; v++) begin
      arm = 4'h1; step(); arm = 0;
      step();
      step();
      if (v == 254) chk("sat_254", 32'(votes_cast), 32'd254);
      if (v == 255) chk("sat_255", 32'(votes_cast), 32'd255);
    end
    chk("sat_256", 32'(votes_cast), 32'd255);
    arm = 4'h1; step(); arm = 0; vote_ready = 0;
    step();
    chk("midhs_valid", 32'(vote_valid), 32'h1);
    #2;
    rst_n = 0;
    #1;
    chk("async_reset", 32'(obs), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1;

    // ---- randomized run against the model ----
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      open_cmd  = ($urandom_range(0, 5) == 0);
      close_cmd = ($urandom_range(0, 29) == 0);
      clear_cmd = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < 4; i++) begin
        arm[i] = ($urandom_range(0, 9) == 0);
        if (!booth_req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            booth_req[i] = 1'b1;
            booth_cand[2*i +: 2] = 2'($urandom_range(0, 3));
          end
        end else if ($urandom_range(0, 39) == 0) begin
          booth_req[i] = 1'b0;
        end
      end
      vote_ready = ($urandom_range(0, 3) != 0);
      step();
      chk($sformatf("rand%0d", c), 32'(obs), 32'(model_obs()));
      booth_req = booth_req & ~m_ack;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
